// File: rtl/rf_pkg.sv
// Shared constants and the dump sequencer state encoding for the register file.
package rf_pkg;

  localparam int RF_DATA_W = 8;
  localparam int RF_ADDR_W = 3;

  typedef enum logic {
    DUMP_IDLE = 1'b0,
    DUMP_SEND = 1'b1
  } dump_state_e;

endpackage : rf_pkg

// File: rtl/reg_file_8x8_if.sv
// Bus bundle for the register file: write port, two read ports, debug dump stream.
// The master side is decode/writeback plus the trace consumer; the slave side is the register file.
interface reg_file_8x8_if
  import rf_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) ();

  // Write port
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  // Read ports
  logic [ADDR_W-1:0] raddr_a;
  logic [ADDR_W-1:0] raddr_b;
  logic [DATA_W-1:0] rdata_a;
  logic [DATA_W-1:0] rdata_b;

  // Debug dump stream
  logic              dump_start;
  logic              dump_busy;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              dump_last;

  modport master (
    output we, waddr, wdata, raddr_a, raddr_b, dump_start, dump_ready,
    input  rdata_a, rdata_b, dump_busy, dump_valid, dump_addr, dump_data, dump_last
  );

  modport slave (
    input  we, waddr, wdata, raddr_a, raddr_b, dump_start, dump_ready,
    output rdata_a, rdata_b, dump_busy, dump_valid, dump_addr, dump_data, dump_last
  );

endinterface : reg_file_8x8_if

// File: rtl/rf_dump_seq.sv
// Debug dump sequencer: walks idx from 0 to NUM_REGS-1 over a valid/ready stream.
// Only the index is produced here; the parent muxes the register data.
module rf_dump_seq
  import rf_pkg::*;
#(
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              ready_i,
  output logic              busy_o,
  output logic              valid_o,
  output logic              last_o,
  output logic [ADDR_W-1:0] idx_o
);

  localparam logic [ADDR_W-1:0] IDX_LAST = '1;

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  // State and index registers; reset aborts any dump in progress.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DUMP_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: start from IDLE, advance on each accepted beat, leave after the last one.
  // NOTE: defaults come first so every path assigns every output and no latch is inferred.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      DUMP_IDLE: begin
        if (start_i) begin
          state_d = DUMP_SEND;
          idx_d   = '0;
        end
      end
      DUMP_SEND: begin
        if (ready_i) begin
          if (idx_q == IDX_LAST) begin
            // Last beat accepted: exit before idx could wrap.
            state_d = DUMP_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = DUMP_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign busy_o  = (state_q == DUMP_SEND);
  assign valid_o = (state_q == DUMP_SEND);
  assign last_o  = (state_q == DUMP_SEND) && (idx_q == IDX_LAST);
  assign idx_o   = idx_q;

endmodule : rf_dump_seq

// File: rtl/reg_file_8x8.sv
// Architectural register file: 8 x 8-bit, one synchronous write port, two
// combinational read ports with write-first bypass, optional hard-wired zero in r0,
// and a debug dump stream of the whole array.
module reg_file_8x8
  import rf_pkg::*;
#(
  parameter int DATA_W  = RF_DATA_W,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter bit R0_ZERO = 1'b1
) (
  input logic            clk,
  input logic            reset,   // asynchronous, active-low
  reg_file_8x8_if.slave  bus
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic              wr_en;
  logic [ADDR_W-1:0] dump_idx;

  // A write to r0 is dropped when r0 is hard-wired to zero.
  assign wr_en = bus.we && !(R0_ZERO && (bus.waddr == '0));

  // Read one port: r0 rule first, then write-first bypass, then the stored value.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              wr,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [DATA_W-1:0] wr_data
  );
    if (R0_ZERO && (addr == '0)) begin
      return '0;
    end else if (wr && (wr_addr == addr)) begin
      return wr_data;
    end else begin
      return stored;
    end
  endfunction

  // Storage array write; reset clears every register immediately.
  // NOTE: this array is reset on purpose (architectural state must read 0 after reset), so it maps to flops, not RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[bus.waddr] <= bus.wdata;
    end
  end

  // Operand read ports.
  assign bus.rdata_a = read_port(bus.raddr_a, regs_q[bus.raddr_a], wr_en, bus.waddr, bus.wdata);
  assign bus.rdata_b = read_port(bus.raddr_b, regs_q[bus.raddr_b], wr_en, bus.waddr, bus.wdata);

  rf_dump_seq #(
    .ADDR_W (ADDR_W)
  ) u_dump_seq (
    .clk     (clk),
    .rst_n   (reset),
    .start_i (bus.dump_start),
    .ready_i (bus.dump_ready),
    .busy_o  (bus.dump_busy),
    .valid_o (bus.dump_valid),
    .last_o  (bus.dump_last),
    .idx_o   (dump_idx)
  );

  // Dump data follows the same rules as an operand read so a stalled beat tracks writes.
  assign bus.dump_addr = dump_idx;
  assign bus.dump_data = read_port(dump_idx, regs_q[dump_idx], wr_en, bus.waddr, bus.wdata);

endmodule : reg_file_8x8
